// File: rtl/event_occupancy_monitor_pkg.sv
// Shared definitions for the event occupancy monitor: FSM state encoding
// and default counter widths.
package event_occupancy_monitor_pkg;

    localparam int CNT_W_DEF   = 6;
    localparam int NSTOP_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_HOLD  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

endpackage

// File: rtl/event_occupancy_monitor_occ_counter.sv
// Saturating up/down occupancy counter. Exposes its next value so the
// caller can compare thresholds on the same edge the count moves.
module occ_counter #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         clr,
    input  logic         en,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic [W-1:0] count_next,
    output logic         ovf,
    output logic         udf
);

    localparam logic [W-1:0] MAX = '1;

    logic [W-1:0] count_reg;

    // Simultaneous inc and dec cancel; saturation raises a one-cycle strobe.
    always_comb begin
        count_next = count_reg;
        ovf        = 1'b0;
        udf        = 1'b0;
        if (clr) begin
            count_next = '0;
        end else if (en && inc && !dec) begin
            if (count_reg == MAX)
                ovf = 1'b1;
            else
                count_next = count_reg + W'(1);
        end else if (en && dec && !inc) begin
            if (count_reg == '0)
                udf = 1'b1;
            else
                count_next = count_reg - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (srst)
            count_reg <= '0;
        else
            count_reg <= count_next;
    end

    assign count = count_reg;

endmodule

// File: rtl/event_occupancy_monitor.sv
// Buffer occupancy monitor: tracks events in flight, requests a trigger
// halt with hysteresis, and keeps run statistics and sticky error flags.
module event_occupancy_monitor
    import event_occupancy_monitor_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int NSTOP_W = NSTOP_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               live_rising,
    input  logic               trig_accepted,
    input  logic               read_complete,
    input  logic [CNT_W-1:0]   stop_hi,
    input  logic [CNT_W-1:0]   resume_lo,
    output logic [CNT_W-1:0]   n_pileup,
    output logic               stop,
    output logic               read_overflow,
    output logic               trig_overflow,
    output logic               cfg_err,
    output logic [CNT_W-1:0]   peak,
    output logic [NSTOP_W-1:0] n_stop,
    output logic [1:0]         state
);

    state_t             state_reg, state_next;
    logic               stop_reg, read_ovf_reg, trig_ovf_reg, cfg_err_reg;
    logic [CNT_W-1:0]   peak_reg;
    logic [NSTOP_W-1:0] n_stop_reg;

    logic [CNT_W-1:0]   occ_next;
    logic               occ_ovf, occ_udf, count_en, cfg_bad, enter_hold;
    logic [CNT_W-1:0]   eff_resume;

    assign count_en = (state_reg != ST_IDLE);

    occ_counter #(.W(CNT_W)) u_occ (
        .clk        (clk),
        .srst       (rst),
        .clr        (live_rising),
        .en         (count_en),
        .inc        (trig_accepted),
        .dec        (read_complete),
        .count      (n_pileup),
        .count_next (occ_next),
        .ovf        (occ_ovf),
        .udf        (occ_udf)
    );

    // An inverted threshold pair collapses hysteresis to a single step.
    assign cfg_bad    = (resume_lo >= stop_hi);
    assign eff_resume = !cfg_bad         ? resume_lo :
                        (stop_hi == '0)  ? '0 : stop_hi - CNT_W'(1);

    always_comb begin
        state_next = state_reg;
        enter_hold = 1'b0;
        if (live_rising) begin
            state_next = ST_RUN;
        end else begin
            case (state_reg)
                ST_IDLE: state_next = ST_IDLE;
                ST_RUN: begin
                    if (occ_udf) begin
                        state_next = ST_FAULT;
                    end else if (occ_next >= stop_hi) begin
                        state_next = ST_HOLD;
                        enter_hold = 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (occ_udf)
                        state_next = ST_FAULT;
                    else if (occ_next <= eff_resume)
                        state_next = ST_RUN;
                end
                default: state_next = ST_FAULT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            stop_reg     <= 1'b0;
            read_ovf_reg <= 1'b0;
            trig_ovf_reg <= 1'b0;
            cfg_err_reg  <= 1'b0;
            peak_reg     <= '0;
            n_stop_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            stop_reg    <= (state_next == ST_HOLD) || (state_next == ST_FAULT);
            cfg_err_reg <= cfg_bad;
            if (live_rising) begin
                read_ovf_reg <= 1'b0;
                trig_ovf_reg <= 1'b0;
                peak_reg     <= '0;
                n_stop_reg   <= '0;
            end else begin
                if (occ_udf)
                    read_ovf_reg <= 1'b1;
                if (occ_ovf)
                    trig_ovf_reg <= 1'b1;
                if (occ_next > peak_reg)
                    peak_reg <= occ_next;
                if (enter_hold && (n_stop_reg != '1))
                    n_stop_reg <= n_stop_reg + NSTOP_W'(1);
            end
        end
    end

    assign stop          = stop_reg;
    assign read_overflow = read_ovf_reg;
    assign trig_overflow = trig_ovf_reg;
    assign cfg_err       = cfg_err_reg;
    assign peak          = peak_reg;
    assign n_stop        = n_stop_reg;
    assign state         = state_reg;

endmodule

// File: tb/tb_event_occupancy_monitor.sv
// Directed table-driven bench for event_occupancy_monitor (CNT_W=6).
module tb_event_occupancy_monitor;

    logic        clk = 1'b0;
    logic        rst, live_rising, trig_accepted, read_complete;
    logic [5:0]  stop_hi, resume_lo;
    logic [5:0]  n_pileup, peak;
    logic        stop, read_overflow, trig_overflow, cfg_err;
    logic [15:0] n_stop;
    logic [1:0]  state;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    event_occupancy_monitor #(.CNT_W(6), .NSTOP_W(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .live_rising   (live_rising),
        .trig_accepted (trig_accepted),
        .read_complete (read_complete),
        .stop_hi       (stop_hi),
        .resume_lo     (resume_lo),
        .n_pileup      (n_pileup),
        .stop          (stop),
        .read_overflow (read_overflow),
        .trig_overflow (trig_overflow),
        .cfg_err       (cfg_err),
        .peak          (peak),
        .n_stop        (n_stop),
        .state         (state)
    );

    typedef struct {
        logic       rst, live, trig, rd;
        logic [5:0] shi, rlo;
        int         reps;
        logic [5:0] n;
        logic       stp;
        logic [1:0] st;
        int         ns;
        logic [5:0] pk;
        logic       ro, to, cfg;
    } vec_t;

    vec_t tbl [23];

    function automatic vec_t mk(logic r, logic l, logic t, logic d, logic [5:0] shi,
                                logic [5:0] rlo, int reps, logic [5:0] n, logic stp,
                                logic [1:0] st, int ns, logic [5:0] pk, logic ro,
                                logic to, logic cfg);
        vec_t v;
        v.rst = r; v.live = l; v.trig = t; v.rd = d; v.shi = shi; v.rlo = rlo;
        v.reps = reps; v.n = n; v.stp = stp; v.st = st; v.ns = ns; v.pk = pk;
        v.ro = ro; v.to = to; v.cfg = cfg;
        return v;
    endfunction

    task automatic chk(string name, int idx, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic step(logic r, logic l, logic t, logic d);
        rst = r; live_rising = l; trig_accepted = t; read_complete = d;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(int idx, logic [5:0] n, logic stp, logic [1:0] st, int ns,
                             logic [5:0] pk, logic ro, logic to, logic cfg);
        chk("n_pileup", idx, n_pileup, n);
        chk("stop", idx, stop, stp);
        chk("state", idx, state, st);
        chk("n_stop", idx, n_stop, ns);
        chk("peak", idx, peak, pk);
        chk("read_overflow", idx, read_overflow, ro);
        chk("trig_overflow", idx, trig_overflow, to);
        chk("cfg_err", idx, cfg_err, cfg);
        $display("step %0d: n=%0d stop=%0d state=%0d n_stop=%0d peak=%0d rovf=%0d tovf=%0d cfg=%0d",
                 idx, n_pileup, stop, state, n_stop, peak, read_overflow, trig_overflow, cfg_err);
    endtask

    initial begin
        //            rst live trig rd  shi rlo reps  n  stp st ns pk ro to cfg
        tbl[0]  = mk(1, 0, 0, 0, 44, 40,  2,  0, 0, 0, 0,  0, 0, 0, 0);
        tbl[1]  = mk(0, 0, 1, 0, 44, 40,  3,  0, 0, 0, 0,  0, 0, 0, 0);
        tbl[2]  = mk(0, 1, 0, 0, 44, 40,  1,  0, 0, 1, 0,  0, 0, 0, 0);
        tbl[3]  = mk(0, 0, 1, 0, 44, 40, 43, 43, 0, 1, 0, 43, 0, 0, 0);
        tbl[4]  = mk(0, 0, 1, 0, 44, 40,  1, 44, 1, 2, 1, 44, 0, 0, 0);
        tbl[5]  = mk(0, 0, 1, 1, 44, 40,  1, 44, 1, 2, 1, 44, 0, 0, 0);
        tbl[6]  = mk(0, 0, 0, 1, 44, 40,  3, 41, 1, 2, 1, 44, 0, 0, 0);
        tbl[7]  = mk(0, 0, 0, 1, 44, 40,  1, 40, 0, 1, 1, 44, 0, 0, 0);
        tbl[8]  = mk(0, 0, 1, 0, 44, 40,  4, 44, 1, 2, 2, 44, 0, 0, 0);
        tbl[9]  = mk(0, 0, 0, 1, 44, 40, 44,  0, 0, 1, 2, 44, 0, 0, 0);
        tbl[10] = mk(0, 0, 0, 1, 44, 40,  1,  0, 1, 3, 2, 44, 1, 0, 0);
        tbl[11] = mk(0, 0, 1, 0, 44, 40,  5,  5, 1, 3, 2, 44, 1, 0, 0);
        tbl[12] = mk(0, 1, 1, 0, 44, 40,  1,  0, 0, 1, 0,  0, 0, 0, 0);
        tbl[13] = mk(0, 0, 1, 0, 63, 62, 62, 62, 0, 1, 0, 62, 0, 0, 0);
        tbl[14] = mk(0, 0, 1, 0, 63, 62,  1, 63, 1, 2, 1, 63, 0, 0, 0);
        tbl[15] = mk(0, 0, 1, 0, 63, 62,  1, 63, 1, 2, 1, 63, 0, 1, 0);
        tbl[16] = mk(0, 1, 0, 0, 10, 20,  1,  0, 0, 1, 0,  0, 0, 0, 1);
        tbl[17] = mk(0, 0, 1, 0, 10, 20,  9,  9, 0, 1, 0,  9, 0, 0, 1);
        tbl[18] = mk(0, 0, 1, 0, 10, 20,  1, 10, 1, 2, 1, 10, 0, 0, 1);
        tbl[19] = mk(0, 0, 0, 1, 10, 20,  1,  9, 0, 1, 1, 10, 0, 0, 1);
        tbl[20] = mk(0, 0, 1, 0, 10, 20,  3, 12, 1, 2, 2, 12, 0, 0, 1);
        tbl[21] = mk(1, 0, 1, 0, 10, 20,  1,  0, 0, 0, 0,  0, 0, 0, 0);
        tbl[22] = mk(0, 0, 0, 0, 10, 20,  1,  0, 0, 0, 0,  0, 0, 0, 1);

        rst = 1'b1; live_rising = 1'b0; trig_accepted = 1'b0; read_complete = 1'b0;
        stop_hi = 6'd44; resume_lo = 6'd40;

        for (int i = 0; i < 23; i++) begin
            stop_hi   = tbl[i].shi;
            resume_lo = tbl[i].rlo;
            for (int r = 0; r < tbl[i].reps; r++)
                step(tbl[i].rst, tbl[i].live, tbl[i].trig, tbl[i].rd);
            check_all(i, tbl[i].n, tbl[i].stp, tbl[i].st, tbl[i].ns, tbl[i].pk,
                      tbl[i].ro, tbl[i].to, tbl[i].cfg);
        end

        // Reset beats live_rising; a mid-run reset drops occupancy for good.
        stop_hi = 6'd44; resume_lo = 6'd40;
        step(1, 1, 0, 0);
        check_all(100, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        check_all(101, 2, 0, 1, 0, 2, 0, 0, 0);
        step(1, 0, 0, 0);
        check_all(102, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0);
        check_all(103, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 1, 0);
        check_all(104, 1, 0, 1, 0, 1, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/event_occupancy_monitor.md
EVENT_OCCUPANCY_MONITOR -- requirements
Module: event_occupancy_monitor

Interface
REQ-001 The block SHALL have parameter CNT_W, default 6: occupancy counter width.
REQ-002 The block SHALL have parameter NSTOP_W, default 16: stop-episode counter width.
REQ-003 The block SHALL have port clk, input, 1: system clock; single clock domain.
REQ-004 The block SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 The block SHALL have port live_rising, input, 1: run-start pulse; clears run state.
REQ-006 The block SHALL have port trig_accepted, input, 1: one event written to buffer.
REQ-007 The block SHALL have port read_complete, input, 1: one event read out.
REQ-008 The block SHALL have port stop_hi, input, CNT_W: stop threshold; stop asserts at occupancy >= stop_hi.
REQ-009 The block SHALL have port resume_lo, input, CNT_W: resume threshold; stop releases at occupancy <= resume_lo.
REQ-010 The block SHALL have port n_pileup, output, CNT_W: current occupancy.
REQ-011 The block SHALL have port stop, output, 1: request to halt triggering.
REQ-012 The block SHALL have port read_overflow, output, 1: sticky; read seen with occupancy 0.
REQ-013 The block SHALL have port trig_overflow, output, 1: sticky; trigger seen with occupancy at 2^CNT_W-1.
REQ-014 The block SHALL have port cfg_err, output, 1: resume_lo >= stop_hi, registered each cycle.
REQ-015 The block SHALL have port peak, output, CNT_W: maximum occupancy seen since run start.
REQ-016 The block SHALL have port n_stop, output, NSTOP_W: count of RUN->HOLD transitions, saturating.
REQ-017 The block SHALL have port state, output, 2: FSM state code.

Function
REQ-018 The block SHALL register every output, updating on the clk edge that samples its inputs (1-cycle latency).
REQ-019 The FSM SHALL have states IDLE=0, RUN=1, HOLD=2, FAULT=3.
REQ-020 The FSM SHALL go from IDLE to RUN on live_rising; trig_accepted and read_complete SHALL be ignored in IDLE.
REQ-021 On live_rising in any state, the block SHALL go to RUN and clear n_pileup, peak, n_stop, read_overflow and trig_overflow; same-cycle trig/read SHALL be ignored.
REQ-022 The occupancy next value in RUN/HOLD SHALL be: trig only +1; read only -1; both or neither unchanged.
REQ-023 A trig alone with n_pileup = 2^CNT_W-1 SHALL leave the count saturated and set trig_overflow.
REQ-024 A read alone with n_pileup = 0 SHALL leave the count at 0, set read_overflow, and move the FSM to FAULT.
REQ-025 In RUN, if next occupancy >= stop_hi, the FSM SHALL move to HOLD and increment n_stop, saturating at all-ones.
REQ-026 In HOLD, if next occupancy <= resume_lo, the FSM SHALL move to RUN; occupancy strictly between the thresholds SHALL hold the current state (hysteresis).
REQ-027 When cfg_err=1, the effective resume threshold SHALL be stop_hi-1 (no hysteresis), or 0 when stop_hi=0.
REQ-028 stop SHALL equal 1 in HOLD and FAULT, and 0 in IDLE and RUN.
REQ-029 In FAULT, counting SHALL continue with saturation rules, stop SHALL stay 1, and exit SHALL be only via live_rising or rst.
REQ-030 peak SHALL be updated to the next occupancy whenever that exceeds peak.
REQ-031 Threshold comparisons SHALL be unsigned at CNT_W bits and use the next occupancy, so stop rises on the same edge the count reaches stop_hi.

Reset
REQ-032 rst SHALL have priority over live_rising.
REQ-033 On rst, state SHALL be IDLE and all counters, flags, peak, stop and cfg_err SHALL be 0.
REQ-034 Reset asserted mid-run SHALL discard occupancy; no event SHALL be replayed.

Structure
REQ-035 A shared package SHALL hold the state encoding constants and the default CNT_W and NSTOP_W.
REQ-036 One sub-module, occ_counter (saturating up/down counter with overflow/underflow strobes), SHALL be instantiated; the FSM, thresholds and statistics SHALL be in the top level.

Verification (CNT_W=6, stop_hi=44, resume_lo=40 unless stated)
REQ-037 rst, live_rising, then 44 trig pulses -> n_pileup=44, stop=1 on the same edge, state=HOLD, n_stop=1, peak=44.
REQ-038 From 44, 3 reads -> stop=1 at 41; 4th read -> n_pileup=40, stop=0, RUN; then trig to 44 again -> n_stop=2.
REQ-039 trig and read in the same cycle at n_pileup=44 -> count stays 44, no state change.
REQ-040 In RUN at 0, read_complete -> read_overflow=1, state=FAULT, stop=1; later live_rising -> all cleared, RUN, stop=0.
REQ-041 stop_hi=63, resume_lo=62, 64 trigs -> n_pileup=63, trig_overflow=1, peak=63.
REQ-042 stop_hi=10, resume_lo=20 -> cfg_err=1; stop rises at 10 and falls at 9; rst mid-run -> all outputs 0, IDLE.
